// File: rtl/tdm_pkg.sv
// Shared constants and slot-counter command encoding for the TDM receive path.
package tdm_pkg;
  localparam int N_SLOTS   = 8;
  localparam int SEL_W     = $clog2(N_SLOTS);
  localparam int LAST_SLOT = N_SLOTS - 1;

  typedef enum logic [2:0] {
    CTR_HOLD   = 3'd0,
    CTR_LOAD1  = 3'd1,
    CTR_INC    = 3'd2,
    CTR_WRAP   = 3'd3,
    CTR_UNLOCK = 3'd4
  } ctr_op_e;
endpackage

// File: rtl/tdm_slot_ctr.sv
// Slot index counter with lock flag; one command per cycle from the framing logic.
module tdm_slot_ctr #(
  parameter int SEL_W = tdm_pkg::SEL_W
) (
  input  logic             clk,
  input  logic             rst,
  input  tdm_pkg::ctr_op_e op,
  output logic [SEL_W-1:0] slot_sel,
  output logic             locked
);
  import tdm_pkg::*;

  logic [SEL_W-1:0] slot_sel_q, slot_sel_d;
  logic             locked_q, locked_d;

  always_comb begin
    slot_sel_d = slot_sel_q;
    locked_d   = locked_q;
    unique case (op)
      CTR_LOAD1: begin
        slot_sel_d = SEL_W'(1);
        locked_d   = 1'b1;
      end
      CTR_INC:    slot_sel_d = slot_sel_q + SEL_W'(1);
      CTR_WRAP:   slot_sel_d = '0;
      CTR_UNLOCK: locked_d   = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_sel_q <= '0;
      locked_q   <= 1'b0;
    end else begin
      slot_sel_q <= slot_sel_d;
      locked_q   <= locked_d;
    end
  end

  assign slot_sel = slot_sel_q;
  assign locked   = locked_q;
endmodule

// File: rtl/tdm_demux1x8.sv
// TDM receive demux: collects one sample per slot into shadow lanes and publishes
// the whole frame at once on y one cycle after the last slot; flags framing errors.
module tdm_demux1x8 #(
  parameter int DATA_W  = 1,
  parameter int N_SLOTS = tdm_pkg::N_SLOTS,
  parameter int SEL_W   = $clog2(N_SLOTS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_W-1:0]         din,
  input  logic                      din_valid,
  input  logic                      frame_sync,
  output logic [N_SLOTS*DATA_W-1:0] y,
  output logic                      frame_valid,
  output logic [SEL_W-1:0]          slot_sel,
  output logic                      locked,
  output logic                      sync_err
);
  import tdm_pkg::*;

  localparam int LAST_IDX = N_SLOTS - 1;

  logic [DATA_W-1:0]         shadow_q [N_SLOTS];
  logic [DATA_W-1:0]         shadow_d [N_SLOTS];
  logic [N_SLOTS*DATA_W-1:0] y_q, y_d;
  logic                      frame_valid_q, frame_valid_d;
  logic                      sync_err_q, sync_err_d;
  ctr_op_e                   ctr_op;

  tdm_slot_ctr #(.SEL_W(SEL_W)) u_ctr (
    .clk      (clk),
    .rst      (rst),
    .op       (ctr_op),
    .slot_sel (slot_sel),
    .locked   (locked)
  );

  always_comb begin
    ctr_op        = CTR_HOLD;
    shadow_d      = shadow_q;
    y_d           = y_q;
    frame_valid_d = 1'b0;
    sync_err_d    = 1'b0;
    if (din_valid) begin
      if (frame_sync) begin
        // Early sync restarts the frame; stale shadow lanes get overwritten before publish.
        ctr_op      = CTR_LOAD1;
        shadow_d[0] = din;
        sync_err_d  = locked && (slot_sel != '0);
      end else if (!locked) begin
        ctr_op = CTR_HOLD;
      end else if (slot_sel == '0) begin
        ctr_op     = CTR_UNLOCK;
        sync_err_d = 1'b1;
      end else if (slot_sel == SEL_W'(LAST_IDX)) begin
        ctr_op = CTR_WRAP;
        for (int k = 0; k < LAST_IDX; k++) begin
          y_d[k*DATA_W +: DATA_W] = shadow_q[k];
        end
        y_d[LAST_IDX*DATA_W +: DATA_W] = din;
        frame_valid_d = 1'b1;
      end else begin
        ctr_op             = CTR_INC;
        shadow_d[slot_sel] = din;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q           <= '0;
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
      for (int k = 0; k < N_SLOTS; k++) begin
        shadow_q[k] <= '0;
      end
    end else begin
      y_q           <= y_d;
      frame_valid_q <= frame_valid_d;
      sync_err_q    <= sync_err_d;
      shadow_q      <= shadow_d;
    end
  end

  assign y           = y_q;
  assign frame_valid = frame_valid_q;
  assign sync_err    = sync_err_q;
endmodule
